// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, state, and the
// datapath mux/imm selects.
package rv_ctrl_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      IMM_I  = 3'd0,
      IMM_IU = 3'd1,
      IMM_S  = 3'd2,
      IMM_B  = 3'd3,
      IMM_U  = 3'd4,
      IMM_J  = 3'd5
   } imm_sel_e;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      PC_SRC_PC4    = 2'd0,
      PC_SRC_BRANCH = 2'd1,
      PC_SRC_ALU    = 2'd2
   } pc_src_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_e;

   typedef enum logic [1:0] {
      ALU_A_RS1    = 2'd0,
      ALU_A_OLD_PC = 2'd1,
      ALU_A_ZERO   = 2'd2
   } alu_src_a_e;

   typedef enum logic [1:0] {
      ALU_B_RS2    = 2'd0,
      ALU_B_IMM    = 2'd1,
      ALU_B_CONST4 = 2'd2
   } alu_src_b_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_SUB   = 2'd1,
      ALU_FUNCT = 2'd2
   } alu_mode_e;

endpackage

// File: rtl/mc_control_if.sv
// Unified memory port handshake between the control FSM (master) and memory (slave).
interface mc_control_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr_sel,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr_sel,
      output mem_ready
   );
endinterface

// File: rtl/imm_sel_decode.sv
// Opcode to immediate-format decode plus a supported-opcode flag; IMM_IU is never produced.
module imm_sel_decode
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   output logic [2:0] o_imm_sel,
   output logic       o_supported
);

   always_comb begin
      o_imm_sel   = IMM_I;
      o_supported = 1'b1;
      case (i_opcode)
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_OP: o_imm_sel = IMM_I;
         OPC_STORE:                              o_imm_sel = IMM_S;
         OPC_BRANCH:                             o_imm_sel = IMM_B;
         OPC_LUI, OPC_AUIPC:                     o_imm_sel = IMM_U;
         OPC_JAL:                                o_imm_sel = IMM_J;
         default:                                o_supported = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Main control FSM of the multicycle RV32I core. Define HALT_ON_ILLEGAL_EN to stop in
// HALT on an unsupported opcode; otherwise such opcodes retire as NOPs.
module mc_control
   import rv_ctrl_pkg::*;
#(
   parameter logic [2:0] RESET_STATE_DBG = 3'd0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_instr,
   input  logic        i_branch_taken,
   mc_control_if.master mem_if,
   output logic        o_ir_write,
   output logic        o_pc_write,
   output logic [1:0]  o_pc_src,
   output logic [1:0]  o_alu_src_a,
   output logic [1:0]  o_alu_src_b,
   output logic [1:0]  o_alu_mode,
   output logic [2:0]  o_imm_sel,
   output logic        o_reg_write,
   output logic [1:0]  o_wb_sel,
   output logic        o_illegal,
   output logic [2:0]  o_state_dbg
);

   state_e     r_state;
   state_e     w_next_state;
   logic [6:0] w_opcode;
   logic [2:0] w_imm_sel;
   logic       w_supported;
   logic       w_unused_instr;

   assign w_opcode       = i_instr[6:0];
   assign w_unused_instr = ^i_instr[31:7];

   imm_sel_decode u_imm_sel_decode (
      .i_opcode    (w_opcode),
      .o_imm_sel   (w_imm_sel),
      .o_supported (w_supported)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StFetch;
      end else begin
         r_state <= w_next_state;
      end
   end

`ifdef HALT_ON_ILLEGAL_EN
   logic r_illegal;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_illegal <= 1'b0;
      end else if (r_state == StDecode && !w_supported) begin
         r_illegal <= 1'b1;
      end
   end
`endif

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         StFetch: begin
            if (mem_if.mem_ready) w_next_state = StDecode;
         end
         StDecode: begin
            if (w_supported) begin
               w_next_state = StExec;
            end else begin
`ifdef HALT_ON_ILLEGAL_EN
               w_next_state = StHalt;
`else
               w_next_state = StFetch;
`endif
            end
         end
         StExec: begin
            case (w_opcode)
               OPC_OP, OPC_OP_IMM, OPC_AUIPC: w_next_state = StWb;
               OPC_LOAD, OPC_STORE:           w_next_state = StMem;
               default:                       w_next_state = StFetch;
            endcase
         end
         StMem: begin
            if (mem_if.mem_ready) begin
               w_next_state = (w_opcode == OPC_LOAD) ? StWb : StFetch;
            end
         end
         StWb:    w_next_state = StFetch;
         StHalt:  w_next_state = StHalt;
         default: w_next_state = StFetch;
      endcase
   end

   always_comb begin
      o_ir_write          = 1'b0;
      o_pc_write          = 1'b0;
      o_pc_src            = PC_SRC_PC4;
      mem_if.mem_req      = 1'b0;
      mem_if.mem_we       = 1'b0;
      mem_if.mem_addr_sel = 1'b0;
      o_alu_src_a         = ALU_A_RS1;
      o_alu_src_b         = ALU_B_RS2;
      o_alu_mode          = ALU_ADD;
      o_imm_sel           = IMM_I;
      o_reg_write         = 1'b0;
      o_wb_sel            = WB_ALU;
      o_illegal           = 1'b0;
      o_state_dbg         = RESET_STATE_DBG;
      if (!i_rst) begin
         o_state_dbg = r_state;
         if (r_state != StHalt) o_imm_sel = w_imm_sel;
         // ALU setup held from EXEC through WB so an unregistered ALU result stays valid.
         if (r_state == StExec || r_state == StMem || r_state == StWb) begin
            case (w_opcode)
               OPC_OP: o_alu_mode = ALU_FUNCT;
               OPC_OP_IMM: begin
                  o_alu_src_b = ALU_B_IMM;
                  o_alu_mode  = ALU_FUNCT;
               end
               OPC_LOAD, OPC_STORE, OPC_JALR: o_alu_src_b = ALU_B_IMM;
               OPC_BRANCH: o_alu_mode = ALU_SUB;
               OPC_AUIPC: begin
                  o_alu_src_a = ALU_A_OLD_PC;
                  o_alu_src_b = ALU_B_IMM;
               end
               default: ;
            endcase
         end
         unique case (r_state)
            StFetch: begin
               mem_if.mem_req = 1'b1;
               if (mem_if.mem_ready) begin
                  o_ir_write = 1'b1;
                  o_pc_write = 1'b1;
               end
            end
            StDecode: o_illegal = !w_supported;
            StExec: begin
               case (w_opcode)
                  OPC_BRANCH: begin
                     o_pc_src   = PC_SRC_BRANCH;
                     o_pc_write = i_branch_taken;
                  end
                  OPC_JAL: begin
                     o_pc_src    = PC_SRC_BRANCH;
                     o_pc_write  = 1'b1;
                     o_reg_write = 1'b1;
                     o_wb_sel    = WB_PC4;
                  end
                  OPC_JALR: begin
                     o_pc_src    = PC_SRC_ALU;
                     o_pc_write  = 1'b1;
                     o_reg_write = 1'b1;
                     o_wb_sel    = WB_PC4;
                  end
                  OPC_LUI: begin
                     o_reg_write = 1'b1;
                     o_wb_sel    = WB_IMM;
                  end
                  default: ;
               endcase
            end
            StMem: begin
               mem_if.mem_req      = 1'b1;
               mem_if.mem_addr_sel = 1'b1;
               mem_if.mem_we       = (w_opcode == OPC_STORE);
            end
            StWb: begin
               o_reg_write = 1'b1;
               o_wb_sel    = (w_opcode == OPC_LOAD) ? WB_MEM : WB_ALU;
            end
            StHalt:  ;
            default: ;
         endcase
`ifdef HALT_ON_ILLEGAL_EN
         o_illegal = o_illegal | r_illegal;
`endif
      end
   end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Main control FSM for the multicycle RV32I core. It sequences one instruction at a time through the shared datapath (PC, IR, register file, ALU, immediate generator, unified memory port). It decodes the latched instruction, drives the immediate generator's imm_sel, and issues per-cycle enables and muxes. Memory handshakes with a request/ready pair.

Parameters:
RESET_STATE_DBG, 0, value reported on state_dbg during reset (debug only, no functional effect)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
instr  in  32  IR contents (valid from DECODE onward)
mem_ready  in  1  memory completes current request this cycle
branch_taken  in  1  branch compare result from ALU/comparator, valid in EXEC
ir_write  out  1  load IR from memory read data
pc_write  out  1  update PC
pc_src  out  2  0 PC+4, 1 old_pc+imm, 2 ALU result with bit0 cleared
mem_req  out  1  memory request
mem_we  out  1  write qualifier for mem_req
mem_addr_sel  out  1  0 PC, 1 ALU result
alu_src_a  out  2  0 rs1, 1 old_pc, 2 zero
alu_src_b  out  2  0 rs2, 1 imm, 2 const 4
alu_mode  out  2  0 add, 1 sub/compare, 2 funct3/funct7 decode
imm_sel  out  3  0 I, 1 I-unsigned, 2 S, 3 B, 4 U, 5 J
reg_write  out  1  register file write enable
wb_sel  out  2  0 ALU, 1 mem data, 2 PC (already +4), 3 imm
illegal  out  1  unsupported opcode detected
state_dbg  out  3  current state encoding

Behaviour:
- Clock and reset: single clock clk. Synchronous active-high rst. While rst=1, all outputs are 0 (state_dbg=RESET_STATE_DBG). The next state after reset is FETCH.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - Stay in FETCH while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - The datapath latches old_pc on ir_write.
- DECODE:
  - imm_sel is decoded from instr[6:0]: OP-IMM/LOAD/JALR→0, STORE→2, BRANCH→3, LUI/AUIPC→4, JAL→5, others→0.
  - imm_sel=1 is never generated by this block.
  - Unsupported opcode: see Optional Feature. Otherwise go to EXEC.
- EXEC, by opcode:
  - OP/OP-IMM: alu_mode=2, alu_src_b=0 or 1. Next state WB.
  - LOAD/STORE: alu_src_b=1, alu_mode=0. Next state MEM.
  - BRANCH: alu_mode=1, pc_src=1, pc_write=branch_taken. Next state FETCH.
  - JAL: reg_write=1, wb_sel=2, pc_write=1, pc_src=1. Next state FETCH.
  - JALR: alu_src_a=0, alu_src_b=1, pc_src=2, pc_write=1, reg_write=1, wb_sel=2. Next state FETCH.
  - LUI: reg_write=1, wb_sel=3. Next state FETCH.
  - AUIPC: alu_src_a=1, alu_src_b=1. Next state WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - Hold all outputs while mem_ready=0.
  - On mem_ready: LOAD→WB, STORE→FETCH.
- WB: reg_write=1; wb_sel=1 for LOAD, else 0. Next state FETCH.
- imm_sel stays valid and stable from DECODE through WB. Its value in FETCH is don't-care.
- Latency with mem_ready tied high:
  - ALU ops and AUIPC: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH, JAL, JALR, LUI: 3 cycles.
- Control outputs are combinational from the registered state and instr. State is the only flop plus the illegal flag.
- rd=x0 writes are still asserted; the register file discards them.
- Reset asserted in any state, including mid-handshake in FETCH/MEM: next state FETCH, request dropped, no write.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
HALT_ON_ILLEGAL_EN.
- Defined: an unsupported opcode in DECODE moves to HALT. illegal=1 sticky, all enables 0, HALT is exited only by rst.
- Undefined: an unsupported opcode is executed as a NOP. illegal pulses for the DECODE cycle, next state FETCH, no writes (PC already advanced in FETCH). HALT is unreachable.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants;
  - the imm_sel encodings (IMM_I, IMM_IU, IMM_S, IMM_B, IMM_U, IMM_J);
  - the state encoding;
  - pc_src, wb_sel, alu_src and alu_mode encodings.
- One combinational sub-module, imm_sel_decode: maps opcode to imm_sel plus a supported flag. It is reused by the verification scoreboard.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready high → states F,D,E,W. imm_sel=0 from D; reg_write=1, wb_sel=0 on cycle 4 only.
- SW x2,8(x1) with mem_ready low for 3 MEM cycles → imm_sel=2. mem_req=1, mem_we=1, mem_addr_sel=1 held 4 cycles, then FETCH; reg_write never asserted.
- BEQ (imm_sel=3):
  - branch_taken=1 → pc_write=1, pc_src=1 in EXEC.
  - branch_taken=0 → pc_write=0.
  - Both return to FETCH after 3 cycles.
- JAL x1,+16 → imm_sel=5. EXEC: pc_write=1, pc_src=1, reg_write=1, wb_sel=2.
- LW x3,0(x1) with rst asserted during MEM → next cycle state FETCH, all outputs 0 during rst, no reg_write.
- Opcode 0x7F:
  - with HALT_ON_ILLEGAL_EN → HALT, illegal stays 1 for 10 cycles, mem_req=0.
  - without → one-cycle illegal pulse, then FETCH.
